// File: rtl/regfile_sequencer.sv
// Initiator for the register-file port: read operands, hand them to the datapath, then write back with a setup/strobe/hold regWeD pulse.
// Optional macro REGSEQ_READBACK_EN adds a VERIFY cycle that reads rd back and flags a mismatch in wb_err.
module regfile_sequencer #(
  parameter int NUM_REGS = 16,
  parameter int DATA_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [4:0]        req_rs_a,
  input  logic [4:0]        req_rs_b,
  input  logic [4:0]        req_rd,
  input  logic              req_use_a,
  input  logic              req_use_b,
  input  logic              req_wb,
  output logic [DATA_W-1:0] op_a,
  output logic [DATA_W-1:0] op_b,
  output logic              op_valid,
  input  logic              op_ready,
  input  logic              wb_valid,
  input  logic [DATA_W-1:0] wb_data,
  output logic              wb_ready,
  output logic              wb_err,
  output logic [4:0]        regAddrA,
  output logic [4:0]        regAddrB,
  output logic [4:0]        regAddrD,
  output logic              regReA,
  output logic              regReB,
  output logic              regWeD,
  input  logic [DATA_W-1:0] busA,
  input  logic [DATA_W-1:0] busB,
  output logic [DATA_W-1:0] busD
);

  localparam logic [5:0] NUM_REGS_W = 6'(NUM_REGS);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_READ      = 3'd1,
    S_EXEC      = 3'd2,
    S_WAIT_WB   = 3'd3,
    S_WB_SETUP  = 3'd4,
    S_WB_STROBE = 3'd5,
    S_WB_HOLD   = 3'd6
`ifdef REGSEQ_READBACK_EN
    , S_VERIFY  = 3'd7
`endif
  } state_t;

  state_t     r_state;
  logic [4:0] r_rd;
  logic       r_use_a;
  logic       r_use_b;
  logic       r_wb;

  logic       w_accept;
  logic       w_rd_zero;
  logic       w_rd_oob;

  assign w_accept  = req_valid & req_ready;
  assign w_rd_zero = (r_rd == 5'd0);
  assign w_rd_oob  = ({1'b0, r_rd} >= NUM_REGS_W);

  // Sequencer state machine; every port output is a register written here.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_rd      <= 5'd0;
      r_use_a   <= 1'b0;
      r_use_b   <= 1'b0;
      r_wb      <= 1'b0;
      req_ready <= 1'b1;
      op_a      <= {DATA_W{1'b0}};
      op_b      <= {DATA_W{1'b0}};
      op_valid  <= 1'b0;
      wb_ready  <= 1'b0;
      wb_err    <= 1'b0;
      regAddrA  <= 5'd0;
      regAddrB  <= 5'd0;
      regAddrD  <= 5'd0;
      regReA    <= 1'b0;
      regReB    <= 1'b0;
      regWeD    <= 1'b0;
      busD      <= {DATA_W{1'b0}};
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_rd      <= req_rd;
            r_use_a   <= req_use_a;
            r_use_b   <= req_use_b;
            r_wb      <= req_wb;
            req_ready <= 1'b0;
            if (req_use_a | req_use_b) begin
              regAddrA <= req_rs_a;
              regAddrB <= req_rs_b;
              regReA   <= req_use_a;
              regReB   <= req_use_b;
              r_state  <= S_READ;
            end else begin
              op_a     <= {DATA_W{1'b0}};
              op_b     <= {DATA_W{1'b0}};
              op_valid <= 1'b1;
              r_state  <= S_EXEC;
            end
          end
        end
        S_READ: begin
          // Read enables drop on the same edge the operands are captured, releasing the buses.
          op_a     <= r_use_a ? busA : {DATA_W{1'b0}};
          op_b     <= r_use_b ? busB : {DATA_W{1'b0}};
          regReA   <= 1'b0;
          regReB   <= 1'b0;
          op_valid <= 1'b1;
          r_state  <= S_EXEC;
        end
        S_EXEC: begin
          if (op_ready) begin
            op_valid <= 1'b0;
            if (r_wb) begin
              wb_ready <= 1'b1;
              r_state  <= S_WAIT_WB;
            end else begin
              req_ready <= 1'b1;
              r_state   <= S_IDLE;
            end
          end
        end
        S_WAIT_WB: begin
          if (wb_valid) begin
            wb_ready <= 1'b0;
            if (w_rd_zero) begin
              req_ready <= 1'b1;
              r_state   <= S_IDLE;
            end else if (w_rd_oob) begin
              wb_err    <= 1'b1;
              req_ready <= 1'b1;
              r_state   <= S_IDLE;
            end else begin
              regAddrD <= r_rd;
              busD     <= wb_data;
              r_state  <= S_WB_SETUP;
            end
          end
        end
        S_WB_SETUP: begin
          regWeD  <= 1'b1;
          r_state <= S_WB_STROBE;
        end
        S_WB_STROBE: begin
          regWeD  <= 1'b0;
          r_state <= S_WB_HOLD;
        end
        S_WB_HOLD: begin
`ifdef REGSEQ_READBACK_EN
          regAddrA <= r_rd;
          regReA   <= 1'b1;
          r_state  <= S_VERIFY;
`else
          req_ready <= 1'b1;
          r_state   <= S_IDLE;
`endif
        end
`ifdef REGSEQ_READBACK_EN
        S_VERIFY: begin
          // busD still holds the data just written, so it is the reference for the readback.
          regReA <= 1'b0;
          if (busA != busD) begin
            wb_err <= 1'b1;
          end
          req_ready <= 1'b1;
          r_state   <= S_IDLE;
        end
`endif
        default: begin
          req_ready <= 1'b1;
          op_valid  <= 1'b0;
          wb_ready  <= 1'b0;
          regReA    <= 1'b0;
          regReB    <= 1'b0;
          regWeD    <= 1'b0;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_sequencer.sv
// Bench for regfile_sequencer: behavioural register file plus a scoreboard of expected register contents and error state.
module tb_regfile_sequencer;
  localparam int NUM_REGS = 16;
  localparam int DATA_W   = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready;
  logic [4:0]  req_rs_a, req_rs_b, req_rd;
  logic        req_use_a, req_use_b, req_wb;
  logic [15:0] op_a, op_b;
  logic        op_valid, op_ready;
  logic        wb_valid;
  logic [15:0] wb_data;
  logic        wb_ready, wb_err;
  logic [4:0]  regAddrA, regAddrB, regAddrD;
  logic        regReA, regReB, regWeD;
  logic [15:0] busA, busB, busD;

  always #5 clk = ~clk;

  regfile_sequencer #(.NUM_REGS(NUM_REGS), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_rs_a(req_rs_a), .req_rs_b(req_rs_b), .req_rd(req_rd),
    .req_use_a(req_use_a), .req_use_b(req_use_b), .req_wb(req_wb),
    .op_a(op_a), .op_b(op_b), .op_valid(op_valid), .op_ready(op_ready),
    .wb_valid(wb_valid), .wb_data(wb_data), .wb_ready(wb_ready), .wb_err(wb_err),
    .regAddrA(regAddrA), .regAddrB(regAddrB), .regAddrD(regAddrD),
    .regReA(regReA), .regReB(regReB), .regWeD(regWeD),
    .busA(busA), .busB(busB), .busD(busD)
  );

  // Behavioural register file: writes on the rising edge of regWeD, r0 hardwired to zero.
  logic [15:0] rf [0:31];
  int          strobe_cnt;
  logic        pl_go;
  logic [4:0]  pl_addr;
  logic [15:0] pl_data;
  logic        corrupt;

  always @(posedge regWeD or posedge pl_go) begin
    if (pl_go) begin
      rf[pl_addr] <= pl_data;
    end else begin
      strobe_cnt <= strobe_cnt + 1;
      if (regAddrD != 5'd0 && int'(regAddrD) < NUM_REGS) rf[regAddrD] <= busD;
    end
  end

  always_comb begin
    busA = 16'hDEAD;
    busB = 16'hDEAD;
    if (regReA) busA = (regAddrA == 5'd0 || int'(regAddrA) >= NUM_REGS) ? 16'h0000 : rf[regAddrA];
    if (regReA && corrupt && regAddrA == 5'd7) busA = ~busA;
    if (regReB) busB = (regAddrB == 5'd0 || int'(regAddrB) >= NUM_REGS) ? 16'h0000 : rf[regAddrB];
  end

  // Scoreboard state
  logic [15:0] exp_rf [0:31];
  logic        exp_err;
  logic [15:0] exp_busd;
  logic [4:0]  exp_addrd;
  int          errors;
  int          checks;

  function automatic logic [15:0] ref_read(input logic [4:0] a);
    if (a == 5'd0 || int'(a) >= NUM_REGS) return 16'h0000;
    return exp_rf[a];
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic preload(input logic [4:0] a, input logic [15:0] d);
    pl_addr = a;
    pl_data = (a == 5'd0) ? 16'h0000 : d;
    pl_go = 1'b1;
    #1;
    pl_go = 1'b0;
    #1;
    exp_rf[a] = pl_data;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = 1'b0; op_ready = 1'b0; wb_valid = 1'b0;
    repeat (2) tick();
    checks++;
    if ({req_ready, regWeD, regReA, regReB, op_valid, wb_ready, wb_err} !== 7'b1000000) begin
      errors++;
      $display("FAIL reset_ctrl: got %b want 1000000", {req_ready, regWeD, regReA, regReB, op_valid, wb_ready, wb_err});
    end
    checks++;
    if ({busD, op_a, op_b, regAddrA, regAddrB, regAddrD} !== 63'd0) begin
      errors++;
      $display("FAIL reset_data: busD=%h op_a=%h op_b=%h addrs=%h/%h/%h want all 0", busD, op_a, op_b, regAddrA, regAddrB, regAddrD);
    end
    rst = 1'b0;
    exp_err = 1'b0; exp_busd = 16'h0; exp_addrd = 5'd0;
    tick();
  endtask

  // One full request: read phase, operands, optional stall, optional writeback.
  task automatic run_txn(input logic [4:0] rs_a, input logic [4:0] rs_b, input logic [4:0] rd,
                         input logic use_a, input logic use_b, input logic wb,
                         input logic [15:0] data, input int stall);
    int n;
    int s0;
    logic [15:0] ea, eb;
    ea = use_a ? ref_read(rs_a) : 16'h0000;
    eb = use_b ? ref_read(rs_b) : 16'h0000;
    n = 0;
    while (req_ready !== 1'b1 && n < 20) begin tick(); n++; end
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL idle_timeout: req_ready=%b want 1", req_ready);
    end
    req_valid = 1'b1; req_rs_a = rs_a; req_rs_b = rs_b; req_rd = rd;
    req_use_a = use_a; req_use_b = use_b; req_wb = wb;
    tick();
    req_valid = 1'b0;
    req_rs_a = 5'($urandom); req_rs_b = 5'($urandom); req_rd = 5'($urandom);
    req_use_a = 1'($urandom); req_use_b = 1'($urandom); req_wb = 1'($urandom);
    if (use_a | use_b) begin
      checks++;
      if ({regReA, regReB, regAddrA, regAddrB, op_valid, req_ready} !== {use_a, use_b, rs_a, rs_b, 2'b00}) begin
        errors++;
        $display("FAIL read_phase: re=%b%b addr=%0d/%0d op_valid=%b rdy=%b want re=%b%b addr=%0d/%0d 0 0",
                 regReA, regReB, regAddrA, regAddrB, op_valid, req_ready, use_a, use_b, rs_a, rs_b);
      end
      tick();
    end
    checks++;
    if ({op_valid, regReA, regReB, req_ready, op_a, op_b} !== {4'b1000, ea, eb}) begin
      errors++;
      $display("FAIL operands: valid=%b re=%b%b rdy=%b a=%h b=%h want 1 00 0 a=%h b=%h",
               op_valid, regReA, regReB, req_ready, op_a, op_b, ea, eb);
    end
    for (int i = 0; i < stall; i++) begin
      req_valid = 1'b1;
      tick();
      checks++;
      if ({op_valid, req_ready, op_a, op_b} !== {2'b10, ea, eb}) begin
        errors++;
        $display("FAIL stall_hold: valid=%b rdy=%b a=%h b=%h want 1 0 %h %h", op_valid, req_ready, op_a, op_b, ea, eb);
      end
    end
    req_valid = 1'b0;
    op_ready = 1'b1;
    tick();
    op_ready = 1'b0;
    checks++;
    if ({op_valid, wb_ready, req_ready} !== (wb ? 3'b010 : 3'b001)) begin
      errors++;
      $display("FAIL exec_exit: valid/wb_ready/req_ready=%b want %b", {op_valid, wb_ready, req_ready}, wb ? 3'b010 : 3'b001);
    end
    if (wb) begin
      s0 = strobe_cnt;
      wb_valid = 1'b1; wb_data = data;
      tick();
      wb_valid = 1'b0; wb_data = 16'($urandom);
      if (rd != 5'd0 && int'(rd) < NUM_REGS) begin
        for (int ph = 0; ph < 3; ph++) begin
          checks++;
          if ({regWeD, regAddrD, busD, wb_ready, req_ready} !== {(ph == 1), rd, data, 2'b00}) begin
            errors++;
            $display("FAIL wb_phase%0d: we=%b addr=%0d data=%h wb_rdy=%b rdy=%b want we=%b addr=%0d data=%h 0 0",
                     ph, regWeD, regAddrD, busD, wb_ready, req_ready, (ph == 1), rd, data);
          end
          tick();
        end
`ifdef REGSEQ_READBACK_EN
        checks++;
        if ({regReA, regAddrA, regWeD, req_ready} !== {1'b1, rd, 2'b00}) begin
          errors++;
          $display("FAIL verify_phase: reA=%b addrA=%0d we=%b rdy=%b want 1 %0d 0 0", regReA, regAddrA, regWeD, req_ready, rd);
        end
        tick();
        if (corrupt && rd == 5'd7) exp_err = 1'b1;
`endif
        exp_rf[rd] = data; exp_busd = data; exp_addrd = rd;
        checks++;
        if (strobe_cnt - s0 != 1 || rf[rd] !== data) begin
          errors++;
          $display("FAIL wb_commit: strobes=%0d r%0d=%h want 1 %h", strobe_cnt - s0, rd, rf[rd], data);
        end
      end else begin
        if (int'(rd) >= NUM_REGS) exp_err = 1'b1;
        checks++;
        if (strobe_cnt != s0 || busD !== exp_busd || regAddrD !== exp_addrd) begin
          errors++;
          $display("FAIL wb_dropped: strobes=%0d busD=%h addrD=%0d want 0 %h %0d", strobe_cnt - s0, busD, regAddrD, exp_busd, exp_addrd);
        end
      end
    end
    checks++;
    if ({req_ready, wb_err, regWeD} !== {1'b1, exp_err, 1'b0}) begin
      errors++;
      $display("FAIL txn_end: rdy=%b wb_err=%b we=%b want 1 %b 0", req_ready, wb_err, regWeD, exp_err);
    end
  endtask

  task automatic test_directed();
    preload(5'd3, 16'h1234);
    preload(5'd5, 16'hBEEF);
    run_txn(5'd3, 5'd5, 5'd0, 1'b1, 1'b1, 1'b0, 16'h0, 0);
    run_txn(5'd0, 5'd0, 5'd7, 1'b0, 1'b0, 1'b1, 16'hA5A5, 0);
    run_txn(5'd7, 5'd7, 5'd0, 1'b1, 1'b1, 1'b0, 16'h0, 0);
    run_txn(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 16'hFFFF, 0);
    run_txn(5'd0, 5'd3, 5'd0, 1'b1, 1'b0, 1'b0, 16'h0, 0);
    run_txn(5'd3, 5'd5, 5'd15, 1'b0, 1'b1, 1'b1, 16'h0F0F, 0);
    run_txn(5'd3, 5'd5, 5'd20, 1'b1, 1'b1, 1'b1, 16'h1111, 0);
    run_txn(5'd15, 5'd3, 5'd16, 1'b1, 1'b1, 1'b1, 16'h2222, 0);
    run_txn(5'd3, 5'd5, 5'd9, 1'b1, 1'b1, 1'b1, 16'h3C3C, 5);
  endtask

  task automatic test_random();
    for (int t = 0; t < 40; t++) begin
      run_txn(5'($urandom), 5'($urandom), 5'($urandom_range(0, 31)), 1'($urandom), 1'($urandom),
              1'($urandom), 16'($urandom), int'($urandom_range(0, 3)));
    end
  endtask

  task automatic test_reset_in_strobe();
    int s0;
    req_valid = 1'b1; req_rd = 5'd7; req_use_a = 1'b0; req_use_b = 1'b0; req_wb = 1'b1;
    tick();
    req_valid = 1'b0;
    op_ready = 1'b1;
    tick();
    op_ready = 1'b0;
    s0 = strobe_cnt;
    wb_valid = 1'b1; wb_data = 16'h5A5A;
    tick();
    wb_valid = 1'b0;
    tick();
    checks++;
    if (regWeD !== 1'b1) begin
      errors++;
      $display("FAIL strobe_reached: regWeD=%b want 1", regWeD);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({regWeD, req_ready, op_valid, wb_ready, wb_err, busD, regAddrD} !== {5'b01000, 16'h0, 5'd0}) begin
      errors++;
      $display("FAIL rst_in_strobe: we=%b rdy=%b ov=%b wbr=%b err=%b busD=%h addrD=%0d want 0 1 0 0 0 0 0",
               regWeD, req_ready, op_valid, wb_ready, wb_err, busD, regAddrD);
    end
    exp_rf[7] = 16'h5A5A; exp_err = 1'b0; exp_busd = 16'h0; exp_addrd = 5'd0;
    repeat (4) tick();
    checks++;
    if (strobe_cnt - s0 != 1 || rf[7] !== 16'h5A5A || regWeD !== 1'b0) begin
      errors++;
      $display("FAIL single_strobe: strobes=%0d r7=%h we=%b want 1 5a5a 0", strobe_cnt - s0, rf[7], regWeD);
    end
    run_txn(5'd7, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 16'h0, 0);
  endtask

`ifdef REGSEQ_READBACK_EN
  task automatic test_readback();
    run_txn(5'd0, 5'd0, 5'd6, 1'b0, 1'b0, 1'b1, 16'h6666, 0);
    corrupt = 1'b1;
    run_txn(5'd0, 5'd0, 5'd7, 1'b0, 1'b0, 1'b1, 16'hC3C3, 0);
    corrupt = 1'b0;
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    errors = 0; checks = 0; corrupt = 1'b0; pl_go = 1'b0; pl_addr = 5'd0; pl_data = 16'h0;
    rst = 1'b1; req_valid = 1'b0; op_ready = 1'b0; wb_valid = 1'b0; wb_data = 16'h0;
    req_rs_a = 5'd0; req_rs_b = 5'd0; req_rd = 5'd0; req_use_a = 1'b0; req_use_b = 1'b0; req_wb = 1'b0;
    for (int a = 0; a < 32; a++) preload(5'(a), 16'($urandom));
    test_reset();
    test_directed();
    test_random();
    test_reset();
    test_reset_in_strobe();
`ifdef REGSEQ_READBACK_EN
    test_readback();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
